// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI byte engine between NUM_REQ requesters,
// with per-device chip selects and a guaranteed cs-high gap between transactions.
module spi_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CS_GAP  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic [NUM_REQ-1:0]     byte_begin,
    input  logic [8*NUM_REQ-1:0]   byte_data,
    output logic [NUM_REQ-1:0]     byte_done,
    output logic [7:0]             rx_byte,
    output logic [NUM_REQ-1:0]     cs_n,
    output logic                   busy,
    output logic                   spi_tx_begin,
    output logic [7:0]             spi_tx_data,
    input  logic                   spi_tx_end,
    input  logic [7:0]             spi_rx_data
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, cs_n_q, cs_n_d, done_q, done_d;
    logic [7:0]         rx_q, rx_d, txd_q, txd_d;
    logic               txb_q, txb_d, busy_q;
    logic [GW-1:0]      gap_q, gap_d;
    logic [OW-1:0]      rr_q, rr_d, own_q, own_d, win;
    logic               found;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[(int'(rr_q) + k) % NUM_REQ]) begin
                win   = OW'((int'(rr_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cs_n_d  = cs_n_q;
        done_d  = '0;
        rx_d    = rx_q;
        txd_d   = txd_q;
        txb_d   = 1'b0;
        gap_d   = gap_q;
        rr_d    = rr_q;
        own_d   = own_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = OWN;
                gnt_d   = NUM_REQ'(1) << win;
                cs_n_d  = ~(NUM_REQ'(1) << win);
                own_d   = win;
                rr_d    = win;
            end
            OWN: if (byte_begin[own_q]) begin
                txd_d   = byte_data[8*own_q +: 8];
                txb_d   = 1'b1;
                state_d = XFER;
            end else if (!req[own_q]) begin
                state_d = GAP;
                gnt_d   = '0;
                cs_n_d  = '1;
                gap_d   = '0;
            end
            XFER: if (spi_tx_end) begin
                rx_d          = spi_rx_data;
                done_d[own_q] = 1'b1;
                state_d       = OWN;
            end
            default: begin
                state_d = (gap_q == GAP_LAST) ? IDLE : GAP;
                gap_d   = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cs_n_q  <= '1;
            done_q  <= '0;
            rx_q    <= '0;
            txd_q   <= '0;
            txb_q   <= 1'b0;
            busy_q  <= 1'b0;
            gap_q   <= '0;
            rr_q    <= OW'(NUM_REQ - 1);
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            txd_q   <= txd_d;
            txb_q   <= txb_d;
            busy_q  <= (state_d != IDLE);
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
        end
    end

    assign gnt          = gnt_q;
    assign cs_n         = cs_n_q;
    assign byte_done    = done_q;
    assign rx_byte      = rx_q;
    assign busy         = busy_q;
    assign spi_tx_begin = txb_q;
    assign spi_tx_data  = txd_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_cs_match:   assert property (@(posedge clk) disable iff (rst) cs_n_q == ~gnt_q);
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed scenario tests for spi_bus_arbiter (NUM_REQ=2, CS_GAP=16).
module tb_spi_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  gnt;
    logic [1:0]  byte_begin = '0;
    logic [15:0] byte_data = '0;
    logic [1:0]  byte_done;
    logic [7:0]  rx_byte;
    logic [1:0]  cs_n;
    logic        busy;
    logic        spi_tx_begin;
    logic [7:0]  spi_tx_data;
    logic        spi_tx_end = 1'b0;
    logic [7:0]  spi_rx_data = '0;
    int checks = 0;
    int errors = 0;

    spi_bus_arbiter #(.NUM_REQ(2), .CS_GAP(16)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .byte_begin(byte_begin),
        .byte_data(byte_data), .byte_done(byte_done), .rx_byte(rx_byte), .cs_n(cs_n),
        .busy(busy), .spi_tx_begin(spi_tx_begin), .spi_tx_data(spi_tx_data),
        .spi_tx_end(spi_tx_end), .spi_rx_data(spi_rx_data)
    );

    always #5 clk = ~clk;

    // Grant must be zero/one-hot and chip selects its exact complement.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((gnt & (gnt - 2'd1)) != 2'b00 || cs_n !== ~gnt) begin
                errors++;
                $display("FAIL invariant: gnt=%b cs_n=%b required onehot0 gnt and cs_n=~gnt", gnt, cs_n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        byte_begin = '0;
        spi_tx_end = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_byte(input int o, input logic [7:0] tx, input logic [7:0] rx);
        logic [1:0] exp_done;
        exp_done = 2'b01 << o;
        byte_begin[o] = 1'b1;
        byte_data[8*o +: 8] = tx;
        tick();
        byte_begin = '0;
        checks++;
        if (spi_tx_begin !== 1'b1 || spi_tx_data !== tx) begin
            errors++;
            $display("FAIL tx_begin: begin=%b data=%h required 1 %h", spi_tx_begin, spi_tx_data, tx);
        end
        spi_tx_end = 1'b1;
        spi_rx_data = rx;
        tick();
        spi_tx_end = 1'b0;
        checks++;
        if (byte_done !== exp_done || rx_byte !== rx || spi_tx_begin !== 1'b0 || cs_n[o] !== 1'b0) begin
            errors++;
            $display("FAIL byte_done: done=%b rx=%h begin=%b cs_n=%b required %b %h 0 cs_n[%0d]=0",
                     byte_done, rx_byte, spi_tx_begin, cs_n, exp_done, rx, o);
        end
        tick();
        checks++;
        if (byte_done !== 2'b00 || cs_n[o] !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b cs_n=%b required 00 and cs_n[%0d]=0", byte_done, cs_n, o);
        end
    endtask

    task automatic drain_gap();
        for (int i = 0; i < 17; i++) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (gnt !== 2'b00 || cs_n !== 2'b11 || busy !== 1'b0 || byte_done !== 2'b00 ||
            rx_byte !== 8'h00 || spi_tx_begin !== 1'b0 || spi_tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: gnt=%b cs_n=%b busy=%b done=%b rx=%h txb=%b txd=%h required 00 11 0 00 00 0 00",
                     gnt, cs_n, busy, byte_done, rx_byte, spi_tx_begin, spi_tx_data);
        end
    endtask

    task automatic test_single();
        req = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b01 || cs_n !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b cs_n=%b busy=%b required 01 10 1", gnt, cs_n, busy);
        end
        do_byte(0, 8'hE8, 8'h11);
        do_byte(0, 8'h00, 8'h22);
        do_byte(0, 8'h00, 8'h33);
        req = 2'b00;
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cs_n !== 2'b11 || gnt !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_gap[%0d]: cs_n=%b gnt=%b busy=%b required 11 00 1", i, cs_n, gnt, busy);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || cs_n !== 2'b11) begin
            errors++;
            $display("FAIL single_idle: busy=%b cs_n=%b required 0 11", busy, cs_n);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL simul_first: gnt=%b required 01", gnt);
        end
        req = 2'b10;
        tick();
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL simul_gap_end: gnt=%b required 00", gnt);
        end
        tick();
        checks++;
        if (gnt !== 2'b10 || cs_n !== 2'b01) begin
            errors++;
            $display("FAIL simul_second: gnt=%b cs_n=%b required 10 01", gnt, cs_n);
        end
        req = 2'b00;
        tick();
        drain_gap();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_gnt;
        int n;
        apply_reset();
        req = 2'b11;
        tick();
        for (int t = 0; t < 6; t++) begin
            exp_gnt = 2'b01 << (t % 2);
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL fair_order[%0d]: gnt=%b required %b", t, gnt, exp_gnt);
            end
            do_byte(t % 2, 8'(8'h40 + t), 8'(8'hC0 + t));
            if (t == 5) begin
                req = 2'b00;
                tick();
            end else begin
                req[t % 2] = 1'b0;
                tick();
                req[t % 2] = 1'b1;
                n = 1;
                for (int w = 0; w < 40 && gnt == 2'b00; w++) begin
                    tick();
                    if (gnt == 2'b00) n++;
                end
                checks++;
                if (n != 17) begin
                    errors++;
                    $display("FAIL fair_gap[%0d]: idle cycles=%0d required 17", t, n);
                end
            end
        end
        drain_gap();
    endtask

    task automatic test_non_owner();
        apply_reset();
        req = 2'b01;
        tick();
        do_byte(0, 8'h5C, 8'h77);
        byte_begin[1] = 1'b1;
        byte_data[15:8] = 8'hAA;
        tick();
        byte_begin = '0;
        checks++;
        if (spi_tx_begin !== 1'b0 || spi_tx_data !== 8'h5C) begin
            errors++;
            $display("FAIL nonowner_begin: begin=%b data=%h required 0 5c", spi_tx_begin, spi_tx_data);
        end
        tick();
        checks++;
        if (byte_done !== 2'b00 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL nonowner_done: done=%b gnt=%b required 00 01", byte_done, gnt);
        end
        byte_begin[0] = 1'b1;
        byte_data[7:0] = 8'h99;
        tick();
        byte_data[7:0] = 8'h66;
        tick();
        byte_begin = '0;
        checks++;
        if (spi_tx_begin !== 1'b0 || spi_tx_data !== 8'h99) begin
            errors++;
            $display("FAIL xfer_begin_ignored: begin=%b data=%h required 0 99", spi_tx_begin, spi_tx_data);
        end
        spi_tx_end = 1'b1;
        spi_rx_data = 8'h44;
        tick();
        spi_tx_end = 1'b0;
        checks++;
        if (byte_done !== 2'b01 || rx_byte !== 8'h44) begin
            errors++;
            $display("FAIL xfer_done: done=%b rx=%h required 01 44", byte_done, rx_byte);
        end
        tick();
        checks++;
        if (spi_tx_begin !== 1'b0 || byte_done !== 2'b00) begin
            errors++;
            $display("FAIL xfer_no_extra: begin=%b done=%b required 0 00", spi_tx_begin, byte_done);
        end
        req = 2'b00;
        tick();
        drain_gap();
    endtask

    task automatic test_release_during_byte();
        apply_reset();
        req = 2'b01;
        tick();
        byte_begin[0] = 1'b1;
        byte_data[7:0] = 8'h12;
        tick();
        byte_begin = '0;
        req = 2'b00;
        tick();
        tick();
        checks++;
        if (cs_n !== 2'b10 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL release_hold: cs_n=%b gnt=%b required 10 01", cs_n, gnt);
        end
        spi_tx_end = 1'b1;
        spi_rx_data = 8'h34;
        tick();
        spi_tx_end = 1'b0;
        checks++;
        if (byte_done !== 2'b01 || rx_byte !== 8'h34 || cs_n !== 2'b10) begin
            errors++;
            $display("FAIL release_done: done=%b rx=%h cs_n=%b required 01 34 10", byte_done, rx_byte, cs_n);
        end
        tick();
        checks++;
        if (cs_n !== 2'b11 || gnt !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL release_gap: cs_n=%b gnt=%b busy=%b required 11 00 1", cs_n, gnt, busy);
        end
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 2'b01;
        tick();
        byte_begin[0] = 1'b1;
        byte_data[7:0] = 8'h55;
        tick();
        byte_begin = '0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cs_n !== 2'b11 || gnt !== 2'b00 || spi_tx_begin !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cs_n=%b gnt=%b txb=%b busy=%b required 11 00 0 0",
                     cs_n, gnt, spi_tx_begin, busy);
        end
        req = 2'b00;
        #1 rst = 1'b0;
        tick();
        spi_tx_end = 1'b1;
        spi_rx_data = 8'hEE;
        tick();
        spi_tx_end = 1'b0;
        checks++;
        if (byte_done !== 2'b00 || rx_byte !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_end: done=%b rx=%h busy=%b required 00 00 0", byte_done, rx_byte, busy);
        end
        req = 2'b10;
        tick();
        checks++;
        if (gnt !== 2'b10 || cs_n !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_grant: gnt=%b cs_n=%b required 10 01", gnt, cs_n);
        end
        do_byte(1, 8'hA5, 8'h5A);
        req = 2'b00;
        tick();
        drain_gap();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_non_owner();
        test_release_during_byte();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
